// File: rtl/instruction_decode.sv
// ID stage: register file, decode into the ID/EX register, branch/jump resolution in ID,
// load-use and branch-operand hazard detection, and steering of the fetch-stage muxes.
module instruction_decode #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ir2,
  input  logic [DATA_W-1:0] pc2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              exm_reg_write,
  input  logic              exm_mem_read,
  input  logic [REG_AW-1:0] exm_dest,
  input  logic [DATA_W-1:0] exm_result,
  output logic [1:0]        pc_sel,
  output logic [1:0]        ir_sel,
  output logic              pc2_sel,
  output logic [DATA_W-1:0] branch_address,
  output logic [DATA_W-1:0] idex_rs_val,
  output logic [DATA_W-1:0] idex_rt_val,
  output logic [DATA_W-1:0] idex_imm,
  output logic [REG_AW-1:0] idex_dest,
  output logic [2:0]        idex_alu_op,
  output logic              idex_alu_src_imm,
  output logic              idex_mem_read,
  output logic              idex_mem_write,
  output logic              idex_reg_write,
  output logic [DATA_W-1:0] idex_pc,
  output logic              illegal_instr
);

  logic [DATA_W-1:0] rf_r [2**REG_AW];

  logic [5:0]        op_s;
  logic [5:0]        funct_s;
  logic [REG_AW-1:0] rs_s;
  logic [REG_AW-1:0] rt_s;
  logic [REG_AW-1:0] rd_s;
  logic [15:0]       imm_s;
  logic              is_r_s, is_addi_s, is_lw_s, is_sw_s, is_beq_s, is_bne_s, is_j_s;
  logic              illegal_s;
  logic [2:0]        alu_op_s;
  logic [DATA_W-1:0] rs_rd_s, rt_rd_s, cmp_a_s, cmp_b_s;
  logic              uses_rs_s, uses_rt_s, is_br_s;
  logic              load_use_s, br_haz_s, stall_s, taken_s, redirect_s, issue_s;

  logic [DATA_W-1:0] idex_rs_val_r, idex_rt_val_r, idex_imm_r, idex_pc_r;
  logic [REG_AW-1:0] idex_dest_r;
  logic [2:0]        idex_alu_op_r;
  logic              idex_alu_src_imm_r, idex_mem_read_r, idex_mem_write_r, idex_reg_write_r;
  logic              illegal_instr_r;

  assign op_s    = ir2[31:26];
  assign rs_s    = ir2[25:21];
  assign rt_s    = ir2[20:16];
  assign rd_s    = ir2[15:11];
  assign funct_s = ir2[5:0];
  assign imm_s   = ir2[15:0];

  // Register file write port; r0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**REG_AW; i++) rf_r[i] <= {DATA_W{1'b0}};
    end else if (wb_we && (wb_addr != {REG_AW{1'b0}})) begin
      rf_r[wb_addr] <= wb_data;
    end
  end

  // Opcode/funct classification
  always_comb begin
    is_r_s = 1'b0; is_addi_s = 1'b0; is_lw_s = 1'b0; is_sw_s = 1'b0;
    is_beq_s = 1'b0; is_bne_s = 1'b0; is_j_s = 1'b0; illegal_s = 1'b0;
    alu_op_s = 3'd0;
    case (op_s)
      6'h00: begin
        if (ir2 == {DATA_W{1'b0}}) begin
          is_r_s = 1'b0;
        end else begin
          case (funct_s)
            6'h20:   begin is_r_s = 1'b1; alu_op_s = 3'd0; end
            6'h22:   begin is_r_s = 1'b1; alu_op_s = 3'd1; end
            6'h24:   begin is_r_s = 1'b1; alu_op_s = 3'd2; end
            6'h25:   begin is_r_s = 1'b1; alu_op_s = 3'd3; end
            6'h2A:   begin is_r_s = 1'b1; alu_op_s = 3'd4; end
            default: illegal_s = 1'b1;
          endcase
        end
      end
      6'h08:   is_addi_s = 1'b1;
      6'h23:   is_lw_s   = 1'b1;
      6'h2B:   is_sw_s   = 1'b1;
      6'h04:   is_beq_s  = 1'b1;
      6'h05:   is_bne_s  = 1'b1;
      6'h02:   is_j_s    = 1'b1;
      default: illegal_s = 1'b1;
    endcase
  end

  // Register reads with same-cycle writeback bypass, then EX/MEM ALU forwarding for compares
  always_comb begin
    if (rs_s == {REG_AW{1'b0}}) rs_rd_s = {DATA_W{1'b0}};
    else if (wb_we && (wb_addr == rs_s)) rs_rd_s = wb_data;
    else rs_rd_s = rf_r[rs_s];
    if (rt_s == {REG_AW{1'b0}}) rt_rd_s = {DATA_W{1'b0}};
    else if (wb_we && (wb_addr == rt_s)) rt_rd_s = wb_data;
    else rt_rd_s = rf_r[rt_s];
    if (exm_reg_write && !exm_mem_read && (exm_dest == rs_s) && (rs_s != {REG_AW{1'b0}}))
      cmp_a_s = exm_result;
    else
      cmp_a_s = rs_rd_s;
    if (exm_reg_write && !exm_mem_read && (exm_dest == rt_s) && (rt_s != {REG_AW{1'b0}}))
      cmp_b_s = exm_result;
    else
      cmp_b_s = rt_rd_s;
  end

  assign is_br_s   = is_beq_s | is_bne_s;
  assign uses_rs_s = is_r_s | is_addi_s | is_lw_s | is_sw_s | is_br_s;
  assign uses_rt_s = is_r_s | is_sw_s | is_br_s;

  assign load_use_s = idex_mem_read_r && (idex_dest_r != {REG_AW{1'b0}}) &&
                      ((uses_rs_s && (idex_dest_r == rs_s)) || (uses_rt_s && (idex_dest_r == rt_s)));
  // A branch cannot compare against a value still in EX, nor a load still in MEM
  assign br_haz_s = is_br_s &&
    (((rs_s != {REG_AW{1'b0}}) && ((idex_reg_write_r && (idex_dest_r == rs_s)) ||
                                   (exm_mem_read && (exm_dest == rs_s)))) ||
     ((rt_s != {REG_AW{1'b0}}) && ((idex_reg_write_r && (idex_dest_r == rt_s)) ||
                                   (exm_mem_read && (exm_dest == rt_s)))));
  assign stall_s    = load_use_s | br_haz_s;
  assign taken_s    = is_j_s | (is_beq_s && (cmp_a_s == cmp_b_s)) | (is_bne_s && (cmp_a_s != cmp_b_s));
  assign redirect_s = taken_s && !stall_s;
  assign issue_s    = !stall_s && (is_r_s | is_addi_s | is_lw_s | is_sw_s);

  assign branch_address = is_j_s ? {pc2[31:28], ir2[25:0], 2'b00}
                                 : pc2 + {{14{imm_s[15]}}, imm_s, 2'b00};

  // Fetch mux steering: reset > stall > redirect > sequential
  always_comb begin
    if (!rst_n) begin
      pc_sel = 2'd0; ir_sel = 2'd1; pc2_sel = 1'b0;
    end else if (stall_s) begin
      pc_sel = 2'd2; ir_sel = 2'd2; pc2_sel = 1'b1;
    end else if (redirect_s) begin
      pc_sel = 2'd3; ir_sel = 2'd1; pc2_sel = 1'b0;
    end else begin
      pc_sel = 2'd1; ir_sel = 2'd0; pc2_sel = 1'b0;
    end
  end

  // ID/EX pipeline register; anything not issued becomes an all-zero bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_rs_val_r <= {DATA_W{1'b0}}; idex_rt_val_r <= {DATA_W{1'b0}};
      idex_imm_r <= {DATA_W{1'b0}}; idex_pc_r <= {DATA_W{1'b0}};
      idex_dest_r <= {REG_AW{1'b0}}; idex_alu_op_r <= 3'd0;
      idex_alu_src_imm_r <= 1'b0; idex_mem_read_r <= 1'b0;
      idex_mem_write_r <= 1'b0; idex_reg_write_r <= 1'b0;
      illegal_instr_r <= 1'b0;
    end else begin
      illegal_instr_r <= illegal_s;
      if (issue_s) begin
        idex_rs_val_r      <= rs_rd_s;
        idex_rt_val_r      <= rt_rd_s;
        idex_imm_r         <= {{16{imm_s[15]}}, imm_s};
        idex_pc_r          <= pc2;
        idex_dest_r        <= is_r_s ? rd_s : ((is_addi_s | is_lw_s) ? rt_s : {REG_AW{1'b0}});
        idex_alu_op_r      <= alu_op_s;
        idex_alu_src_imm_r <= is_addi_s | is_lw_s | is_sw_s;
        idex_mem_read_r    <= is_lw_s;
        idex_mem_write_r   <= is_sw_s;
        idex_reg_write_r   <= is_r_s | is_addi_s | is_lw_s;
      end else begin
        idex_rs_val_r <= {DATA_W{1'b0}}; idex_rt_val_r <= {DATA_W{1'b0}};
        idex_imm_r <= {DATA_W{1'b0}}; idex_pc_r <= {DATA_W{1'b0}};
        idex_dest_r <= {REG_AW{1'b0}}; idex_alu_op_r <= 3'd0;
        idex_alu_src_imm_r <= 1'b0; idex_mem_read_r <= 1'b0;
        idex_mem_write_r <= 1'b0; idex_reg_write_r <= 1'b0;
      end
    end
  end

  assign idex_rs_val      = idex_rs_val_r;
  assign idex_rt_val      = idex_rt_val_r;
  assign idex_imm         = idex_imm_r;
  assign idex_pc          = idex_pc_r;
  assign idex_dest        = idex_dest_r;
  assign idex_alu_op      = idex_alu_op_r;
  assign idex_alu_src_imm = idex_alu_src_imm_r;
  assign idex_mem_read    = idex_mem_read_r;
  assign idex_mem_write   = idex_mem_write_r;
  assign idex_reg_write   = idex_reg_write_r;
  assign illegal_instr    = illegal_instr_r;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed self-checking bench for instruction_decode: reset, regfile bypass, hazards,
// branch/jump redirects, illegal opcodes and back-to-back issue.
module tb_instruction_decode;
  logic        clk;
  logic        rst_n;
  logic [31:0] ir2, pc2, wb_data, exm_result;
  logic        wb_we, exm_reg_write, exm_mem_read;
  logic [4:0]  wb_addr, exm_dest;
  logic [1:0]  pc_sel, ir_sel;
  logic        pc2_sel;
  logic [31:0] branch_address, idex_rs_val, idex_rt_val, idex_imm, idex_pc;
  logic [4:0]  idex_dest;
  logic [2:0]  idex_alu_op;
  logic        idex_alu_src_imm, idex_mem_read, idex_mem_write, idex_reg_write, illegal_instr;
  int          checks;
  int          errors;

  instruction_decode dut (
    .clk(clk), .rst_n(rst_n), .ir2(ir2), .pc2(pc2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
    .exm_dest(exm_dest), .exm_result(exm_result),
    .pc_sel(pc_sel), .ir_sel(ir_sel), .pc2_sel(pc2_sel), .branch_address(branch_address),
    .idex_rs_val(idex_rs_val), .idex_rt_val(idex_rt_val), .idex_imm(idex_imm),
    .idex_dest(idex_dest), .idex_alu_op(idex_alu_op), .idex_alu_src_imm(idex_alu_src_imm),
    .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
    .idex_reg_write(idex_reg_write), .idex_pc(idex_pc), .illegal_instr(illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    ir2 = 32'd0; wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ir2 = 32'd0; pc2 = 32'd0; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    exm_reg_write = 1'b0; exm_mem_read = 1'b0; exm_dest = 5'd0; exm_result = 32'd0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (pc_sel !== 2'd0) begin errors++; $display("FAIL rst_pc_sel got %0d exp 0", pc_sel); end
    checks++; if (ir_sel !== 2'd1) begin errors++; $display("FAIL rst_ir_sel got %0d exp 1", ir_sel); end
    checks++; if (idex_reg_write !== 1'b0) begin errors++; $display("FAIL rst_reg_write got %0b exp 0", idex_reg_write); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++; if (pc_sel !== 2'd1) begin errors++; $display("FAIL rel_pc_sel got %0d exp 1", pc_sel); end
    checks++; if (ir_sel !== 2'd0) begin errors++; $display("FAIL rel_ir_sel got %0d exp 0", ir_sel); end
    tick();
  endtask

  task automatic test_regfile_bypass();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    ir2 = enc_r(5'd5, 5'd0, 5'd3, 6'h20); pc2 = 32'h40;
    tick();
    checks++; if (idex_rs_val !== 32'hDEAD_BEEF) begin errors++; $display("FAIL byp_rs got %h exp deadbeef", idex_rs_val); end
    checks++; if (idex_dest !== 5'd3 || idex_reg_write !== 1'b1) begin errors++; $display("FAIL byp_dest got %0d/%0b exp 3/1", idex_dest, idex_reg_write); end
    checks++; if (idex_pc !== 32'h40) begin errors++; $display("FAIL byp_pc got %h exp 40", idex_pc); end
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    ir2 = enc_r(5'd0, 5'd5, 5'd6, 6'h22);
    tick();
    checks++; if (idex_rs_val !== 32'd0 || idex_rt_val !== 32'hDEAD_BEEF) begin errors++; $display("FAIL r0_byp got %h/%h exp 0/deadbeef", idex_rs_val, idex_rt_val); end
    checks++; if (idex_alu_op !== 3'd1) begin errors++; $display("FAIL sub_op got %0d exp 1", idex_alu_op); end
    wb_we = 1'b0;
    ir2 = enc_r(5'd0, 5'd0, 5'd6, 6'h25);
    tick();
    checks++; if (idex_rs_val !== 32'd0 || idex_rt_val !== 32'd0) begin errors++; $display("FAIL r0_write got %h/%h exp 0/0", idex_rs_val, idex_rt_val); end
  endtask

  task automatic test_load_use();
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'h55);
    ir2 = enc_i(6'h23, 5'd1, 5'd2, 16'd4); pc2 = 32'h80;
    tick();
    checks++; if (idex_mem_read !== 1'b1 || idex_dest !== 5'd2 || idex_imm !== 32'd4 || idex_rs_val !== 32'd7)
      begin errors++; $display("FAIL lw_issue got mr=%0b d=%0d imm=%h rs=%h exp 1/2/4/7", idex_mem_read, idex_dest, idex_imm, idex_rs_val); end
    ir2 = enc_r(5'd2, 5'd1, 5'd4, 6'h20); pc2 = 32'h84;
    #1;
    checks++; if (pc_sel !== 2'd2 || ir_sel !== 2'd2 || pc2_sel !== 1'b1) begin errors++; $display("FAIL lu_stall got %0d/%0d/%0b exp 2/2/1", pc_sel, ir_sel, pc2_sel); end
    tick();
    checks++; if (idex_reg_write !== 1'b0 || idex_mem_read !== 1'b0 || idex_dest !== 5'd0) begin errors++; $display("FAIL lu_bubble got rw=%0b mr=%0b d=%0d exp 0/0/0", idex_reg_write, idex_mem_read, idex_dest); end
    checks++; if (pc_sel !== 2'd1) begin errors++; $display("FAIL lu_release got %0d exp 1", pc_sel); end
    tick();
    checks++; if (idex_dest !== 5'd4 || idex_rs_val !== 32'h55 || idex_rt_val !== 32'd7) begin errors++; $display("FAIL lu_issue got d=%0d rs=%h rt=%h exp 4/55/7", idex_dest, idex_rs_val, idex_rt_val); end
  endtask

  task automatic test_branch();
    ir2 = enc_i(6'h04, 5'd1, 5'd1, 16'd3); pc2 = 32'h100;
    #1;
    checks++; if (pc_sel !== 2'd3 || ir_sel !== 2'd1 || pc2_sel !== 1'b0) begin errors++; $display("FAIL beq_sel got %0d/%0d/%0b exp 3/1/0", pc_sel, ir_sel, pc2_sel); end
    checks++; if (branch_address !== 32'h10C) begin errors++; $display("FAIL beq_addr got %h exp 10c", branch_address); end
    tick();
    checks++; if (idex_reg_write !== 1'b0 || idex_dest !== 5'd0) begin errors++; $display("FAIL beq_bubble got %0b/%0d exp 0/0", idex_reg_write, idex_dest); end
    ir2 = enc_i(6'h05, 5'd1, 5'd1, 16'd3);
    #1;
    checks++; if (pc_sel !== 2'd1 || ir_sel !== 2'd0) begin errors++; $display("FAIL bne_nt got %0d/%0d exp 1/0", pc_sel, ir_sel); end
    tick();
    checks++; if (idex_reg_write !== 1'b0 || idex_mem_write !== 1'b0) begin errors++; $display("FAIL bne_bubble got %0b/%0b exp 0/0", idex_reg_write, idex_mem_write); end
    ir2 = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF); pc2 = 32'h0;
    #1;
    checks++; if (pc_sel !== 2'd3 || branch_address !== 32'hFFFF_FFFC) begin errors++; $display("FAIL beq_wrap got %0d/%h exp 3/fffffffc", pc_sel, branch_address); end
    tick();
  endtask

  task automatic test_forward();
    wb_write(5'd8, 32'd9);
    exm_reg_write = 1'b1; exm_mem_read = 1'b0; exm_dest = 5'd7; exm_result = 32'd9;
    ir2 = enc_i(6'h04, 5'd7, 5'd8, 16'd1); pc2 = 32'h200;
    #1;
    checks++; if (pc_sel !== 2'd3 || branch_address !== 32'h204) begin errors++; $display("FAIL fwd_taken got %0d/%h exp 3/204", pc_sel, branch_address); end
    exm_mem_read = 1'b1;
    #1;
    checks++; if (pc_sel !== 2'd2 || pc2_sel !== 1'b1) begin errors++; $display("FAIL fwd_load_stall got %0d/%0b exp 2/1", pc_sel, pc2_sel); end
    tick();
    exm_reg_write = 1'b0; exm_mem_read = 1'b0; exm_dest = 5'd0; exm_result = 32'd0;
    ir2 = enc_i(6'h08, 5'd0, 5'd9, 16'd5); pc2 = 32'h300;
    tick();
    checks++; if (idex_reg_write !== 1'b1 || idex_dest !== 5'd9 || idex_alu_src_imm !== 1'b1 || idex_imm !== 32'd5)
      begin errors++; $display("FAIL addi got rw=%0b d=%0d src=%0b imm=%h exp 1/9/1/5", idex_reg_write, idex_dest, idex_alu_src_imm, idex_imm); end
    ir2 = enc_i(6'h04, 5'd9, 5'd0, 16'd1); pc2 = 32'h304;
    #1;
    checks++; if (pc_sel !== 2'd2) begin errors++; $display("FAIL ex_br_stall got %0d exp 2", pc_sel); end
    tick();
    checks++; if (pc_sel !== 2'd3 || branch_address !== 32'h308) begin errors++; $display("FAIL ex_br_after got %0d/%h exp 3/308", pc_sel, branch_address); end
    tick();
  endtask

  task automatic test_jump_illegal();
    ir2 = {6'h02, 26'h000_0040}; pc2 = 32'hF000_0004;
    #1;
    checks++; if (pc_sel !== 2'd3 || branch_address !== 32'hF000_0100) begin errors++; $display("FAIL j_target got %0d/%h exp 3/f0000100", pc_sel, branch_address); end
    tick();
    ir2 = 32'hFC00_0000; pc2 = 32'h500;
    #1;
    checks++; if (pc_sel !== 2'd1) begin errors++; $display("FAIL ill_sel got %0d exp 1", pc_sel); end
    tick();
    checks++; if (illegal_instr !== 1'b1 || idex_reg_write !== 1'b0) begin errors++; $display("FAIL ill_pulse got %0b/%0b exp 1/0", illegal_instr, idex_reg_write); end
    ir2 = 32'd0;
    tick();
    checks++; if (illegal_instr !== 1'b0) begin errors++; $display("FAIL ill_clear got %0b exp 0", illegal_instr); end
  endtask

  task automatic test_back_to_back();
    ir2 = enc_r(5'd1, 5'd2, 5'd11, 6'h2A); pc2 = 32'h600;
    tick();
    checks++; if (idex_alu_op !== 3'd4 || idex_dest !== 5'd11) begin errors++; $display("FAIL slt got %0d/%0d exp 4/11", idex_alu_op, idex_dest); end
    ir2 = enc_i(6'h2B, 5'd2, 5'd1, 16'hFFF0); pc2 = 32'h604;
    tick();
    checks++; if (idex_mem_write !== 1'b1 || idex_reg_write !== 1'b0 || idex_dest !== 5'd0 || idex_imm !== 32'hFFFF_FFF0)
      begin errors++; $display("FAIL sw got mw=%0b rw=%0b d=%0d imm=%h exp 1/0/0/fffffff0", idex_mem_write, idex_reg_write, idex_dest, idex_imm); end
    checks++; if (idex_rs_val !== 32'h55 || idex_rt_val !== 32'd7) begin errors++; $display("FAIL sw_vals got %h/%h exp 55/7", idex_rs_val, idex_rt_val); end
    ir2 = enc_r(5'd1, 5'd2, 5'd12, 6'h24); pc2 = 32'h608;
    tick();
    checks++; if (idex_alu_op !== 3'd2 || idex_dest !== 5'd12 || idex_pc !== 32'h608) begin errors++; $display("FAIL and got %0d/%0d/%h exp 2/12/608", idex_alu_op, idex_dest, idex_pc); end
  endtask

  task automatic test_reset_mid_stall();
    ir2 = enc_i(6'h23, 5'd1, 5'd2, 16'd0); pc2 = 32'h700;
    tick();
    ir2 = enc_r(5'd2, 5'd1, 5'd4, 6'h20);
    #1;
    checks++; if (pc_sel !== 2'd2) begin errors++; $display("FAIL pre_rst_stall got %0d exp 2", pc_sel); end
    rst_n = 1'b0;
    #1;
    checks++; if (idex_mem_read !== 1'b0 || idex_dest !== 5'd0) begin errors++; $display("FAIL rst_clear got %0b/%0d exp 0/0", idex_mem_read, idex_dest); end
    checks++; if (pc_sel !== 2'd0 || ir_sel !== 2'd1) begin errors++; $display("FAIL rst_stall_sel got %0d/%0d exp 0/1", pc_sel, ir_sel); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_regfile_bypass();
    test_load_use();
    test_branch();
    test_forward();
    test_jump_illegal();
    test_back_to_back();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
